// File: rtl/crypto_cmd_sequencer.sv
// crypto_cmd_sequencer: frames one header byte plus BLOCK_BYTES operand bytes
// from an inbound byte stream, launches a block-wide crypto core with a single
// start pulse, waits for completion under a timeout, then streams the result
// block back out byte-by-byte under valid/ready.
module crypto_cmd_sequencer #(
    parameter int BLOCK_BYTES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               core_op,
    output logic [8*BLOCK_BYTES-1:0] core_din,
    output logic                     core_start,
    input  logic                     core_busy,
    input  logic                     core_done,
    input  logic [8*BLOCK_BYTES-1:0] core_dout,
    output logic                     busy,
    output logic                     err
);

    localparam int CNT_W = $clog2(BLOCK_BYTES);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [8*BLOCK_BYTES-1:0] r_buf;
    logic [CNT_W-1:0]         r_byte_cnt;
    logic [TMR_W-1:0]         r_timer;
    logic [1:0]               r_core_op;
    logic                     r_err;

    logic w_last_byte;
    logic w_hdr_ok;
    logic w_hdr_bad;
    logic w_load_wr;
    logic w_done_take;
    logic w_timeout;
    logic w_drain_xfer;

    // The byte counter doubles as the LOAD write pointer and the DRAIN read pointer.
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    // Datapath outputs come straight from registers; busy is a pure state decode.
    assign busy     = (r_state != S_IDLE);
    assign err      = r_err;
    assign core_op  = r_core_op;
    assign core_din = r_buf;
    assign out_data = r_buf[{r_byte_cnt, 3'b000} +: 8];

    // State register: the only control state in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, handshake outputs and datapath strobes decoded from state.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        w_state_nxt  = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        core_start   = 1'b0;
        w_hdr_ok     = 1'b0;
        w_hdr_bad    = 1'b0;
        w_load_wr    = 1'b0;
        w_done_take  = 1'b0;
        w_timeout    = 1'b0;
        w_drain_xfer = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data[7:4] == 4'hA && in_data[3:2] == 2'b00) begin
                        w_hdr_ok    = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_hdr_bad = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load_wr = 1'b1;
                    if (w_last_byte) begin
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                core_start = !core_busy;
                if (!core_busy) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (core_done) begin
                    w_done_take = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else if (r_timer == LAST_TICK) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_drain_xfer = 1'b1;
                    if (w_last_byte) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Block buffer: filled byte-wise in LOAD, replaced wholesale on core completion.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffer is reset because it drives core_din and out_data directly and must read as zero after reset.
        if (!rst_n) begin
            r_buf <= '0;
        end else if (w_load_wr) begin
            r_buf[{r_byte_cnt, 3'b000} +: 8] <= in_data;
        end else if (w_done_take) begin
            r_buf <= core_dout;
        end
    end

    // Byte pointer: cleared on entry to LOAD/DRAIN, held at the last index on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
        end else if (w_hdr_ok || w_done_take) begin
            r_byte_cnt <= '0;
        end else if ((w_load_wr || w_drain_xfer) && !w_last_byte) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    // WAIT timer: cleared by the launch pulse, counts each WAIT cycle that neither completes nor times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (core_start) begin
            r_timer <= '0;
        end else if (r_state == S_WAIT && !core_done && !w_timeout) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Operation select latched from a valid header only; bad headers leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_op <= 2'b00;
        end else if (w_hdr_ok) begin
            r_core_op <= in_data[1:0];
        end
    end

    // Registered error pulse: one cycle after a bad header or a WAIT timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_hdr_bad || w_timeout;
        end
    end

endmodule

// File: tb/tb_crypto_cmd_sequencer.sv
// Scoreboard bench for crypto_cmd_sequencer: directed commands push expected
// core launches and result bytes into queues; a monitor pops and compares them
// whenever the DUT presents a start pulse or an output byte.
module tb_crypto_cmd_sequencer;

    localparam int BB = 16;
    localparam int TO = 8;

    typedef struct {
        logic [1:0]      op;
        logic [8*BB-1:0] din;
    } start_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [1:0]      core_op;
    logic [8*BB-1:0] core_din;
    logic            core_start;
    logic            core_busy;
    logic            core_done = 1'b0;
    logic [8*BB-1:0] core_dout = '0;
    logic            busy;
    logic            err;

    int         n_checks    = 0;
    int         n_errors    = 0;
    int         err_cycles  = 0;
    int         start_cycles = 0;
    int         done_delay  = 0;
    bit         stress      = 1'b0;
    start_t     exp_start_q[$];
    logic [7:0] exp_out_q[$];

    crypto_cmd_sequencer #(
        .BLOCK_BYTES   (BB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .core_op   (core_op),
        .core_din  (core_din),
        .core_start(core_start),
        .core_busy (core_busy),
        .core_done (core_done),
        .core_dout (core_dout),
        .busy      (busy),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stimulus changes one time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit sent;
        sent = 1'b0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 200 && !sent; n++) begin
            @(negedge clk);
            if (in_ready) sent = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!sent) check("in_accept_timeout", 128'(in_ready), 128'(1));
    endtask

    // Header plus BLOCK_BYTES bytes base, base+1, ...; the core model returns the bitwise inverse.
    task automatic run_cmd(input logic [7:0] hdr, input logic [7:0] base, input bit gaps, input bit expect_out);
        start_t     e;
        logic [7:0] b;
        e.op  = hdr[1:0];
        e.din = '0;
        for (int i = 0; i < BB; i++) begin
            b = base + 8'(i);
            e.din[8*i +: 8] = b;
            if (expect_out) exp_out_q.push_back(b ^ 8'hFF);
        end
        exp_start_q.push_back(e);
        send_byte(hdr, gaps);
        for (int i = 0; i < BB; i++) send_byte(e.din[8*i +: 8], gaps);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_out_q.size() != 0) && n < budget);
        if (busy) check("idle_timeout", 128'(busy), 128'(0));
        tick();
    endtask

    task automatic bad_header(input logic [7:0] h);
        send_byte(h, 1'b0);
        @(negedge clk);
        check("bad_hdr_err", 128'(err), 128'(1));
        check("bad_hdr_idle", 128'(busy), 128'(0));
        tick();
        @(negedge clk);
        check("bad_hdr_err_single", 128'(err), 128'(0));
        tick();
    endtask

    // Model core: done delay cycles after the start cycle, result = ~operand.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_dout = ~core_din;
                end
            end
            if (core_start && done_delay > 0) cnt = done_delay;
        end
    end

    // Sink ready: always high, or random stalls in stress mode.
    initial forever begin
        tick();
        out_ready = stress ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compares launches and every presented output byte against the queues.
    initial begin
        start_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (err) err_cycles++;
                if (core_start) begin
                    start_cycles++;
                    if (exp_start_q.size() == 0) begin
                        check("core_start_unexpected", 128'(core_start), 128'(0));
                    end else begin
                        e = exp_start_q.pop_front();
                        check("start_core_op", 128'(core_op), 128'(e.op));
                        check("start_core_din", core_din, e.din);
                    end
                end
                if (out_valid) begin
                    if (exp_out_q.size() == 0) begin
                        check("out_valid_unexpected", 128'(out_valid), 128'(0));
                    end else begin
                        check("out_data", 128'(out_data), 128'(exp_out_q[0]));
                        if (out_ready) void'(exp_out_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int s0;
        int e0;
        int k;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        core_busy = 1'b0;
        rst_n     = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_core_start", 128'(core_start), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_core_din", core_din, 128'(0));
        check("rst_core_op", 128'(core_op), 128'(0));
        rst_n = 1'b1;
        tick();

        // Reset in the middle of LOAD discards the partial block.
        send_byte(8'hA1, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 1'b0);
        @(negedge clk);
        check("partial_din", 128'(core_din[39:0]), 128'(40'h15_14_13_12_11));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_err", 128'(err), 128'(0));
        check("midrst_core_din", core_din, 128'(0));
        #1 rst_n = 1'b1;
        tick();

        // Nominal command with exact launch and turnaround timing.
        s0 = start_cycles;
        e0 = err_cycles;
        done_delay = 5;
        run_cmd(8'hA2, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("start_latency", 128'(core_start), 128'(1));
        check("nominal_core_op", 128'(core_op), 128'(2));
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("nominal_turnaround", 128'(k), 128'(22));
        check("nominal_one_start", 128'(start_cycles - s0), 128'(1));
        check("nominal_no_err", 128'(err_cycles - e0), 128'(0));
        tick();

        // Handshake stress: random input gaps and output stalls.
        s0 = start_cycles;
        stress = 1'b1;
        run_cmd(8'hA2, 8'h00, 1'b1, 1'b1);
        wait_idle(1000);
        stress = 1'b0;
        tick();
        check("stress_one_start", 128'(start_cycles - s0), 128'(1));

        // Bad headers: one err pulse each, no launch, core_op untouched.
        s0 = start_cycles;
        e0 = err_cycles;
        bad_header(8'h51);
        bad_header(8'hA4);
        check("bad_hdr_err_count", 128'(err_cycles - e0), 128'(2));
        check("bad_hdr_no_start", 128'(start_cycles - s0), 128'(0));
        check("bad_hdr_core_op", 128'(core_op), 128'(2));
        run_cmd(8'hA0, 8'h30, 1'b0, 1'b1);
        @(negedge clk);
        check("hdr_a0_core_op", 128'(core_op), 128'(0));
        wait_idle(200);

        // core_busy holds off the launch; then the core never finishes.
        s0 = start_cycles;
        e0 = err_cycles;
        core_busy  = 1'b1;
        done_delay = -1;
        run_cmd(8'hA3, 8'h80, 1'b0, 1'b0);
        repeat (20) begin
            @(negedge clk);
            check("start_while_busy", 128'(core_start), 128'(0));
            tick();
        end
        core_busy = 1'b0;
        @(negedge clk);
        check("start_on_release", 128'(core_start), 128'(1));
        repeat (8) @(negedge clk);
        check("err_before_timeout", 128'(err), 128'(0));
        check("busy_before_timeout", 128'(busy), 128'(1));
        @(negedge clk);
        check("timeout_err", 128'(err), 128'(1));
        check("timeout_idle", 128'(busy), 128'(0));
        @(negedge clk);
        check("timeout_err_single", 128'(err), 128'(0));
        check("timeout_one_start", 128'(start_cycles - s0), 128'(1));
        check("timeout_err_count", 128'(err_cycles - e0), 128'(1));
        tick();

        // Done lands on the final timeout cycle: completion wins.
        e0 = err_cycles;
        done_delay = 8;
        run_cmd(8'hA1, 8'h40, 1'b0, 1'b1);
        @(negedge clk);
        check("late_start", 128'(core_start), 128'(1));
        repeat (9) @(negedge clk);
        check("late_done_drain", 128'(out_valid), 128'(1));
        check("late_done_no_err", 128'(err), 128'(0));
        wait_idle(200);
        check("late_done_err_count", 128'(err_cycles - e0), 128'(0));

        check("sb_out_empty", 128'(exp_out_q.size()), 128'(0));
        check("sb_start_empty", 128'(exp_start_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/crypto_cmd_sequencer.md
# crypto_cmd_sequencer

Byte-serial command sequencer between the 8-bit TinyTapeout pin interface and a block-wide cryptographic core. It frames one header byte plus a block of operand bytes from the input stream, launches the core with a single start pulse, and waits for completion under a timeout. It then streams the result block back out byte-by-byte under a valid/ready handshake. The tile top instantiates it between the pin muxing and the cipher/hash core.

## Interface

Parameters:
- BLOCK_BYTES, 16, operand/result block size in bytes; must be ≥ 2.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before abort; must be ≥ 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  8  inbound byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts in_data. A byte transfers on a clock edge where in_valid and in_ready are both high.
- out_data  out  8  outbound result byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data.
- core_op  out  2  operation select to the core, latched from the header.
- core_din  out  8*BLOCK_BYTES  operand block; byte i is at bits [8i+7:8i].
- core_start  out  1  one-cycle launch pulse.
- core_busy  in  1  core cannot accept a start.
- core_done  in  1  one-cycle completion pulse.
- core_dout  in  8*BLOCK_BYTES  result block, valid in the core_done cycle.
- busy  out  1  high whenever state ≠ IDLE.
- err  out  1  one-cycle error pulse.

## Operation

- States: IDLE, LOAD, START, WAIT, DRAIN. The state register is the only control state. in_ready, out_valid, core_start and busy are decoded combinationally from it.
- IDLE: in_ready=1.
  - An accepted byte is treated as the header.
  - Valid header: bits[7:4]=4'hA and bits[3:2]=2'b00. Latch core_op=bits[1:0], clear byte_cnt, go to LOAD.
  - Invalid header: err=1 for the next cycle, stay in IDLE, leave core_op unchanged.
- LOAD: in_ready=1.
  - Each accepted byte is written to buffer[byte_cnt], then byte_cnt increments.
  - Accepting byte index BLOCK_BYTES-1 moves to START.
  - Gaps in in_valid are allowed and have no timeout.
- START: in_ready=0.
  - core_start = !core_busy.
  - When core_start is high, go to WAIT and clear the timer. Otherwise hold in START indefinitely.
- WAIT: in_ready=0.
  - core_done=1: copy core_dout into the buffer, clear byte_cnt, go to DRAIN.
  - Else if timer==TIMEOUT_CYCLES-1: err=1 for the next cycle, go to IDLE. The buffer is not updated.
  - Else timer increments.
  - If core_done coincides with the timeout cycle, done wins.
- DRAIN: out_valid=1, out_data=buffer[byte_cnt].
  - On out_ready, byte_cnt increments. Transferring byte BLOCK_BYTES-1 returns to IDLE.
  - out_data is stable while out_valid=1 and out_ready=0.
- core_din is driven from the buffer at all times. It is stable from the START cycle through WAIT.
- core_done outside WAIT is ignored. core_busy outside START is ignored.
- byte_cnt width is clog2(BLOCK_BYTES); it never wraps within a state. Timer width is clog2(TIMEOUT_CYCLES).

## Timing

- Reset (rst_n=0, asynchronous): state=IDLE; buffer, byte_cnt, timer, core_op=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=0, core_start=0, busy=0, err=0, core_din=0.
  - Deassertion is sampled at the next clk edge.
  - Reset mid-operation aborts immediately: no err pulse, no further core_start, partial blocks discarded.
- With continuous in_valid, header accepted at edge E0 and data bytes at E1..E16 (BLOCK_BYTES=16). core_start is high in the cycle after E16, provided core_busy=0.
- core_done in cycle C: out_valid=1 with byte 0 in cycle C+1. With out_ready held high, the last byte transfers at edge C+16 and in_ready=1 in cycle C+17.
- err is registered and asserts in the cycle after the triggering event, for exactly one cycle.
- At most one core_start per command. The minimum command turnaround is BLOCK_BYTES+1 input cycles, plus 1 start cycle, plus core latency, plus BLOCK_BYTES drain cycles.

## Test plan

- Reset mid-LOAD: send header 0xA1 and 5 bytes, pulse rst_n low. Required: in_ready=1, busy=0, err=0, core_din=0 asynchronously. The next full command completes normally.
- Nominal: send header 0xA2 then bytes 0x00..0x0F. Required:
  - core_op=2.
  - core_din byte i = i.
  - Exactly one core_start.
  - Model core returns done 5 cycles later with dout byte i = i^0xFF; out stream is 0xFF,0xFE,…,0xF0, then busy=0.
- Handshake stress: random in_valid and out_ready gaps. Required: identical data to the nominal case, and out_data held stable during every out_ready=0 stall.
- Bad header 0x51, then 0xA4. Required: each gives a single err pulse, state stays IDLE, no core_start; the following header 0xA0 is accepted.
- Busy/timeout: hold core_busy=1 for 20 cycles after LOAD. Required: core_start is low throughout and rises the cycle busy drops. Then never assert done with TIMEOUT_CYCLES=8. Required: err pulses after 8 WAIT cycles, no out_valid, back to IDLE.
- Done on the final timeout cycle (timer=7): required DRAIN entry with no err.
